// File: rtl/fifo_pkg.sv
// Shared constants and Gray/binary helpers for the asynchronous FIFO.
// Both the write-side and read-side pointer blocks use these.
package fifo_pkg;

  // Default pointer width. The FIFO depth is 2**(PTR_W-1).
  localparam int PTR_W = 5;
  localparam int DEPTH = 2 ** (PTR_W - 1);

  // Binary to Gray conversion. Zero-extend narrower values into the 32-bit
  // argument; the low bits of the result are the narrow Gray code.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary conversion. Each binary bit is the XOR reduction of every
  // Gray bit at or above it. Zero-extension does not change the low bits.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    for (int i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a multi-bit Gray-coded bus crossing into clk.
// Only one bit changes at a time, so per-bit synchronisation is safe.
module sync_2ff #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q1_q, q1_d;
  logic [W-1:0] q2_q, q2_d;

  // Next values of the two synchroniser stages.
  always_comb begin
    q1_d = d;
    q2_d = q1_q;
  end

  // Synchroniser stages, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1_q <= '0;
      q2_q <= '0;
    end else begin
      q1_q <= q1_d;
      q2_q <= q2_d;
    end
  end

  assign q = q2_q;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer, full flag and fill level for the asynchronous FIFO.
// Optional feature: define FIFO_ALMOST_FULL_EN to build the registered
// almost-full flag; otherwise walmost_full is tied low.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int n         = PTR_W,
  parameter int AF_THRESH = 2 ** (n - 1) - 2
) (
  input  logic         wclk,
  input  logic         wrst_n,
  input  logic         winc,
  input  logic [n-1:0] rptr_g,
  output logic         wen,
  output logic [n-2:0] waddr_g,
  output logic [n-1:0] wptr_g,
  output logic         wfull,
  output logic [n-1:0] wlevel,
  output logic         walmost_full
);

  localparam int DEPTH_N = 2 ** (n - 1);

  // Elaboration guard against unusable parameter combinations.
  if (n < 3 || n > 31 || AF_THRESH < 0 || AF_THRESH > DEPTH_N) begin : g_bad_param
    $error("fifo_wptr_full: unsupported n or AF_THRESH");
  end

  logic [n-1:0] wbin_q, wbin_d;
  logic [n-1:0] wptr_g_q, wptr_g_d;
  logic [n-1:0] wlevel_q, wlevel_d;
  logic         wfull_q, wfull_d;

  logic [n-1:0] rq2;
  logic [n-1:0] rbin_s;
  logic [n-1:0] wbnext;
  logic [n-1:0] wgnext;
  logic [n-2:0] wlow;

  sync_2ff #(.W(n)) u_rsync (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d     (rptr_g),
    .q     (rq2)
  );

  // Write handshake: the producer offers a word with winc; it is taken in
  // any cycle where wfull is low (wen high), otherwise it is dropped and the
  // producer must hold winc. No RAM write is issued while reset is asserted.
  assign wen = winc & ~wfull_q & wrst_n;

  // Next pointer, Gray pointer, full and level computed from the synchronised
  // read pointer. The flags use the possibly stale rq2, so they can only err
  // towards full.
  always_comb begin
    wbnext   = wbin_q + {{(n-1){1'b0}}, wen};
    wgnext   = wbnext ^ (wbnext >> 1);
    rbin_s   = n'(gray2bin({{(32-n){1'b0}}, rq2}));
    wfull_d  = (wgnext == {~rq2[n-1], ~rq2[n-2], rq2[n-3:0]});
    wlevel_d = wbnext - rbin_s;
    wbin_d   = wbnext;
    wptr_g_d = wgnext;
  end

  // RAM address: (n-1)-bit Gray code of the low binary pointer bits, which is
  // not the same as the low bits of the n-bit Gray pointer.
  always_comb begin
    wlow    = wbin_q[n-2:0];
    waddr_g = wlow ^ (wlow >> 1);
  end

  // Pointer and flag registers, cleared asynchronously.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wptr_g_q <= '0;
      wfull_q  <= 1'b0;
      wlevel_q <= '0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_g_q <= wptr_g_d;
      wfull_q  <= wfull_d;
      wlevel_q <= wlevel_d;
    end
  end

  assign wptr_g = wptr_g_q;
  assign wfull  = wfull_q;
  assign wlevel = wlevel_q;

`ifdef FIFO_ALMOST_FULL_EN
  logic walmost_full_q, walmost_full_d;

  // Almost-full follows the next level so it lines up with wlevel.
  always_comb begin
    walmost_full_d = (int'({{(32-n){1'b0}}, wlevel_d}) >= AF_THRESH);
  end

  // Almost-full register.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      walmost_full_q <= 1'b0;
    end else begin
      walmost_full_q <= walmost_full_d;
    end
  end

  assign walmost_full = walmost_full_q;
`else
  assign walmost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full. The reference model tracks total
// writes and reads as plain integers; level is their difference as seen
// through a two-edge read-pointer delay.
module tb_fifo_wptr_full;

  localparam int N  = 5;
  localparam int D  = 16;
  localparam int AF = 14;
`ifdef FIFO_ALMOST_FULL_EN
  localparam bit AF_ON = 1'b1;
`else
  localparam bit AF_ON = 1'b0;
`endif

  logic         wclk = 1'b0;
  logic         wrst_n;
  logic         winc;
  logic [N-1:0] rptr_g;
  logic         wen;
  logic [N-2:0] waddr_g;
  logic [N-1:0] wptr_g;
  logic         wfull;
  logic [N-1:0] wlevel;
  logic         walmost_full;

  fifo_wptr_full #(.n(N), .AF_THRESH(AF)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .rptr_g       (rptr_g),
    .wen          (wen),
    .waddr_g      (waddr_g),
    .wptr_g       (wptr_g),
    .wfull        (wfull),
    .wlevel       (wlevel),
    .walmost_full (walmost_full)
  );

  // Clock.
  always #5 wclk = ~wclk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: total writes, reader count, reader count as seen
  // one and two edges ago, and the resulting flags.
  int m_wr, m_rd, m_r1, m_r2, m_lvl;
  bit m_full, m_af;

  wire [15:0] obs_regs = {wptr_g, waddr_g, wfull, wlevel, walmost_full};

  function automatic logic [N-1:0] g5(input int v);
    logic [N-1:0] b;
    b = v[N-1:0];
    return b ^ (b >> 1);
  endfunction

  function automatic logic [N-2:0] g4(input int v);
    logic [N-2:0] b;
    b = v[N-2:0];
    return b ^ (b >> 1);
  endfunction

  function automatic logic [15:0] exp_regs();
    logic [N-1:0] l;
    l = m_lvl[N-1:0];
    return {g5(m_wr), g4(m_wr), m_full, l, m_af};
  endfunction

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_r1 = 0; m_r2 = 0; m_lvl = 0;
    m_full = 1'b0; m_af = 1'b0;
  endtask

  // Driver: apply inputs on the falling edge.
  task automatic drive(input bit w);
    @(negedge wclk);
    winc   = w;
    rptr_g = g5(m_rd);
    #1;
  endtask

  // Advance one rising edge and update the model.
  task automatic clock_edge();
    bit acc;
    acc = winc && !m_full;
    @(posedge wclk);
    if (acc) m_wr++;
    m_lvl  = m_wr - m_r2;
    m_full = (m_lvl == D);
    m_af   = AF_ON && (m_lvl >= AF);
    m_r2   = m_r1;
    m_r1   = m_rd;
    #1;
  endtask

  task automatic do_reset();
    @(negedge wclk);
    #2;
    wrst_n = 1'b0;
    winc   = 1'b0;
    rptr_g = '0;
    model_reset();
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  task automatic test_reset();
    wrst_n = 1'b0; winc = 1'b0; rptr_g = '0;
    model_reset();
    #1;
    n_cmp++;
    if ({wen, obs_regs} !== 17'h0) begin
      n_bad++; $display("FAIL reset_initial got=%h want=0", {wen, obs_regs});
    end
    repeat (2) @(negedge wclk);
    wrst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1);
      clock_edge();
    end
    n_cmp++;
    if (obs_regs !== exp_regs()) begin
      n_bad++; $display("FAIL reset_prewrite got=%h want=%h", obs_regs, exp_regs());
    end
    // Assert reset in the middle of a cycle while a write is requested.
    @(negedge wclk);
    winc = 1'b1;
    #2;
    wrst_n = 1'b0;
    #1;
    n_cmp++;
    if ({wen, waddr_g, wptr_g, wfull, wlevel} !== 16'h0) begin
      n_bad++; $display("FAIL reset_midstream got=%h want=0", {wen, waddr_g, wptr_g, wfull, wlevel});
    end
    model_reset();
    winc = 1'b0;
    repeat (2) @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  task automatic test_fill();
    m_rd = 0;
    for (int i = 0; i < D; i++) begin
      drive(1'b1);
      n_cmp++;
      if (wen !== 1'b1) begin
        n_bad++; $display("FAIL fill_wen i=%0d got=%b want=1", i, wen);
      end
      clock_edge();
      n_cmp++;
      if (obs_regs !== exp_regs() || wlevel !== 5'(i + 1)) begin
        n_bad++; $display("FAIL fill_regs i=%0d got=%h want=%h", i, obs_regs, exp_regs());
      end
    end
    n_cmp++;
    if (wfull !== 1'b1 || wptr_g !== 5'b11000) begin
      n_bad++; $display("FAIL fill_full got full=%b wptr=%b want full=1 wptr=11000", wfull, wptr_g);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1);
      n_cmp++;
      if (wen !== 1'b0) begin
        n_bad++; $display("FAIL overflow_wen i=%0d got=%b want=0", i, wen);
      end
      clock_edge();
      n_cmp++;
      if (obs_regs !== exp_regs() || wptr_g !== 5'b11000 || wlevel !== 5'd16) begin
        n_bad++; $display("FAIL overflow_regs i=%0d got=%h want=%h", i, obs_regs, exp_regs());
      end
    end
  endtask

  task automatic test_release();
    m_rd = 1;
    for (int e = 1; e <= 3; e++) begin
      drive(1'b0);
      clock_edge();
      n_cmp++;
      if (wfull !== (e < 3) || obs_regs !== exp_regs()) begin
        n_bad++; $display("FAIL release_edge e=%0d got=%h want=%h", e, obs_regs, exp_regs());
      end
    end
    n_cmp++;
    if (wlevel !== 5'd15) begin
      n_bad++; $display("FAIL release_level got=%0d want=15", wlevel);
    end
  endtask

  task automatic test_wrap();
    bit saw_full = 1'b0;
    bit saw_wrap = 1'b0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      m_rd = (m_wr >= 4) ? m_wr - 4 : 0;
      drive(1'b1);
      n_cmp++;
      if (wen !== 1'b1) begin
        n_bad++; $display("FAIL wrap_wen i=%0d got=%b want=1", i, wen);
      end
      clock_edge();
      if (wfull) saw_full = 1'b1;
      if (m_wr == 32 && wptr_g === 5'b00000) saw_wrap = 1'b1;
      n_cmp++;
      if (obs_regs !== exp_regs()) begin
        n_bad++; $display("FAIL wrap_regs i=%0d got=%h want=%h", i, obs_regs, exp_regs());
      end
    end
    m_rd = m_wr - 4;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0);
      clock_edge();
    end
    n_cmp++;
    if (saw_full || !saw_wrap || wlevel !== 5'd4 || wptr_g !== g5(40)) begin
      n_bad++; $display("FAIL wrap_summary got full_seen=%b wrap_seen=%b level=%0d wptr=%b want 0 1 4 %b",
                        saw_full, saw_wrap, wlevel, wptr_g, g5(40));
    end
  endtask

  task automatic test_random();
    bit w;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      w = 1'($urandom_range(0, 1));
      if (m_rd < m_wr && $urandom_range(0, 2) == 0) m_rd++;
      drive(w);
      n_cmp++;
      if (wen !== (w && !m_full)) begin
        n_bad++; $display("FAIL random_wen i=%0d got=%b want=%b", i, wen, w && !m_full);
      end
      clock_edge();
      n_cmp++;
      if (obs_regs !== exp_regs()) begin
        n_bad++; $display("FAIL random_regs i=%0d got=%h want=%h", i, obs_regs, exp_regs());
      end
    end
  endtask

  task automatic test_almost_full();
    do_reset();
    for (int i = 1; i <= AF; i++) begin
      drive(1'b1);
      clock_edge();
      n_cmp++;
      if (walmost_full !== (AF_ON && i == AF) || obs_regs !== exp_regs()) begin
        n_bad++; $display("FAIL af_fill i=%0d got af=%b regs=%h want af=%b regs=%h",
                          i, walmost_full, obs_regs, AF_ON && i == AF, exp_regs());
      end
    end
    m_rd = 1;
    for (int e = 1; e <= 3; e++) begin
      drive(1'b0);
      clock_edge();
    end
    n_cmp++;
    if (walmost_full !== 1'b0 || wlevel !== 5'd13) begin
      n_bad++; $display("FAIL af_drop got af=%b level=%0d want af=0 level=13", walmost_full, wlevel);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_release();
    test_wrap();
    test_random();
    test_almost_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
